// File: rtl/garage_door_timed_ctrl.sv
// Garage door controller with travel timeout and optional auto-close.
// Optional feature macro: AUTO_CLOSE_EN (auto-close after the door has been
// fully open for AUTO_CLOSE cycles). Without it the door stays open until
// the next button press.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | motors off, door at a limit or stopped mid-travel
// MV_UP   | raise motor on
// MV_DN   | lower motor on (beam break reverses to MV_UP)
// FAULT   | motors off, fault lamp on, left only through RST
module garage_door_timed_ctrl #(
    parameter logic [15:0] TRAVEL_MAX = 16'd1000,
    parameter logic [15:0] AUTO_CLOSE = 16'd5000,
    parameter int          CNT_W      = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic Activate,
    input  logic UP_Max,
    input  logic DN_MAX,
    input  logic Obstruct,
    output logic UP_M,
    output logic DN_M,
    output logic Fault
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MV_UP = 2'd1;
    localparam logic [1:0] S_MV_DN = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_MAX - 16'd1);
    localparam logic [CNT_W-1:0] CLOSE_LAST  = CNT_W'(AUTO_CLOSE - 16'd1);
    localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};

`ifdef AUTO_CLOSE_EN
    localparam logic AC_ON = 1'b1;
`else
    localparam logic AC_ON = 1'b0;
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_dir_q, last_dir_d;
    logic             act_q, act_d;

    logic act_edge;
    logic both_lim;
    logic open_timing;

    assign act_edge    = Activate & ~act_q;
    assign both_lim    = UP_Max & DN_MAX;
    // Open dwell only runs while fully open, limits sane and the beam clear.
    assign open_timing = AC_ON & UP_Max & ~DN_MAX & ~Obstruct;

    // Next-state and travel-direction memory.
    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        act_d      = Activate;
        case (state_q)
            S_IDLE: begin
                if (both_lim) begin
                    state_d = S_FAULT;
                end else if (act_edge) begin
                    if (UP_Max)                    state_d = S_MV_DN;
                    else if (DN_MAX)               state_d = S_MV_UP;
                    else if (last_dir_q == DIR_UP) state_d = S_MV_DN;
                    else                           state_d = S_MV_UP;
                end else if (open_timing && cnt_q == CLOSE_LAST) begin
                    state_d = S_MV_DN;
                end
            end
            S_MV_UP: begin
                if (both_lim) begin
                    state_d = S_FAULT;
                end else if (UP_Max || act_edge) begin
                    state_d    = S_IDLE;
                    last_dir_d = DIR_UP;
                end else if (cnt_q == TRAVEL_LAST) begin
                    state_d = S_FAULT;
                end
            end
            S_MV_DN: begin
                if (both_lim) begin
                    state_d = S_FAULT;
                end else if (DN_MAX) begin
                    state_d    = S_IDLE;
                    last_dir_d = DIR_DN;
                end else if (Obstruct) begin
                    state_d = S_MV_UP;
                end else if (act_edge) begin
                    state_d    = S_IDLE;
                    last_dir_d = DIR_DN;
                end else if (cnt_q == TRAVEL_LAST) begin
                    state_d = S_FAULT;
                end
            end
            default: state_d = S_FAULT;
        endcase
    end

    // Shared counter: motion time while moving, open dwell while idle.
    always_comb begin
        cnt_d = '0;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == S_MV_UP || state_q == S_MV_DN ||
                     (state_q == S_IDLE && open_timing)) begin
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // State registers; act_q tracks the button even in reset so a held
    // button does not look like a fresh press at reset release.
    always_ff @(posedge CLK) begin
        act_q <= act_d;
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_dir_q <= DIR_DN;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_dir_q <= last_dir_d;
        end
    end

    assign UP_M  = (state_q == S_MV_UP);
    assign DN_M  = (state_q == S_MV_DN);
    assign Fault = (state_q == S_FAULT);

endmodule
